// File: rtl/ddfs_dual_dac_spi_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : ddfs_dual_dac_spi_driver_if
// Purpose  : Bundles the sample/handshake inputs, status outputs and the
//            dual-DAC SPI pins of ddfs_dual_dac_spi_driver.
// Signals  : enable      - level capture request (sampled only when idle)
//            COSINE_IN   - signed cosine sample, DAC channel A
//            SINE_IN     - signed sine sample, DAC channel B
//            DAC_SCLK    - SPI clock, idle low
//            DAC_MOSI    - SPI data, MSB first
//            DAC_CS_N    - active-low chip select
//            DAC_LDAC_N  - active-low DAC latch strobe
//            BUSY        - transaction in progress
//            FRAME_DONE  - one-cycle completion pulse
// Modports : master - sample source / observer side
//            slave  - the SPI driver
// Revision : 1.0 - initial release
// ============================================================================
interface ddfs_dual_dac_spi_driver_if #(
  parameter int DATA_W = 16
);
  logic              enable;
  logic [DATA_W-1:0] COSINE_IN;
  logic [DATA_W-1:0] SINE_IN;
  logic              DAC_SCLK;
  logic              DAC_MOSI;
  logic              DAC_CS_N;
  logic              DAC_LDAC_N;
  logic              BUSY;
  logic              FRAME_DONE;

  modport master (
    output enable, COSINE_IN, SINE_IN,
    input  DAC_SCLK, DAC_MOSI, DAC_CS_N, DAC_LDAC_N, BUSY, FRAME_DONE
  );

  modport slave (
    input  enable, COSINE_IN, SINE_IN,
    output DAC_SCLK, DAC_MOSI, DAC_CS_N, DAC_LDAC_N, BUSY, FRAME_DONE
  );
endinterface
`default_nettype wire

// File: rtl/ddfs_dual_dac_spi_driver.sv
`default_nettype none
// ============================================================================
// Module   : ddfs_dual_dac_spi_driver
// Purpose  : Captures a DDFS cosine/sine sample pair, converts each to
//            offset-binary DAC codes and sends them as two SPI frames
//            (channel A then B) to a dual 12-bit DAC, then pulses LDAC_N so
//            both outputs update together.
// Ports    : clock_100_MHz - system clock, rising edge
//            clear_DAC     - asynchronous active-high reset
//            bus           - ddfs_dual_dac_spi_driver_if.slave (samples,
//                            enable, SPI pins, BUSY, FRAME_DONE)
// Revision : 1.0 - initial release
// ============================================================================
module ddfs_dual_dac_spi_driver #(
  parameter int DATA_W   = 16,
  parameter int DAC_BITS = 12,
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 2,
  parameter int LDAC_W   = 2
) (
  input  logic                          clock_100_MHz,
  input  logic                          clear_DAC,
  ddfs_dual_dac_spi_driver_if.slave     bus
);

  // Frame = {A/B, BUF, GA_n, SHDN_n, code}
  localparam int FRAME_W = DAC_BITS + 4;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AUX_MAX = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
  localparam int AUX_W   = (AUX_MAX > 1) ? $clog2(AUX_MAX) : 1;

  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
  localparam logic [AUX_W-1:0] c_gap_last = AUX_W'(CS_GAP - 1);
  localparam logic [AUX_W-1:0] c_lat_last = AUX_W'(LDAC_W - 1);
  localparam logic [3:0]       c_hdr_a    = 4'b0011;
  localparam logic [3:0]       c_hdr_b    = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT_A = 3'd1,
    S_GAP_A   = 3'd2,
    S_SHIFT_B = 3'd3,
    S_GAP_B   = 3'd4,
    S_LATCH   = 3'd5
  } state_t;

  state_t               r_state,   w_state;
  logic [DAC_BITS-1:0]  r_code_b,  w_code_b;
  logic [FRAME_W-1:0]   r_shreg,   w_shreg;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt;
  logic [DIV_W-1:0]     r_div_cnt, w_div_cnt;
  logic [AUX_W-1:0]     r_aux_cnt, w_aux_cnt;
  logic                 r_sclk,    w_sclk;
  logic                 r_cs_n,    w_cs_n;
  logic                 r_ldac_n,  w_ldac_n;
  logic                 r_done,    w_done;

  // Truncate to the top DAC_BITS and flip the sign bit: two's complement
  // becomes offset binary.
  logic [DAC_BITS-1:0]  w_code_a_in;
  logic [DAC_BITS-1:0]  w_code_b_in;
  logic [FRAME_W-1:0]   w_word_a;
  logic [FRAME_W-1:0]   w_word_b;

  assign w_code_a_in = {~bus.COSINE_IN[DATA_W-1], bus.COSINE_IN[DATA_W-2 -: DAC_BITS-1]};
  assign w_code_b_in = {~bus.SINE_IN[DATA_W-1],   bus.SINE_IN[DATA_W-2 -: DAC_BITS-1]};
  assign w_word_a    = {c_hdr_a, w_code_a_in};
  assign w_word_b    = {c_hdr_b, r_code_b};

  // Sample LSBs below the DAC resolution are intentionally discarded.
  generate
    if (DATA_W > DAC_BITS) begin : g_lsb_sink
      wire logic w_unused_lsbs = ^{bus.COSINE_IN[DATA_W-DAC_BITS-1:0],
                                   bus.SINE_IN[DATA_W-DAC_BITS-1:0]};
    end
  endgenerate

  always_ff @(posedge clock_100_MHz or posedge clear_DAC) begin
    if (clear_DAC) begin
      r_state   <= S_IDLE;
      r_code_b  <= '0;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_aux_cnt <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ldac_n  <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_code_b  <= w_code_b;
      r_shreg   <= w_shreg;
      r_bit_cnt <= w_bit_cnt;
      r_div_cnt <= w_div_cnt;
      r_aux_cnt <= w_aux_cnt;
      r_sclk    <= w_sclk;
      r_cs_n    <= w_cs_n;
      r_ldac_n  <= w_ldac_n;
      r_done    <= w_done;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_code_b  = r_code_b;
    w_shreg   = r_shreg;
    w_bit_cnt = r_bit_cnt;
    w_div_cnt = r_div_cnt;
    w_aux_cnt = r_aux_cnt;
    w_sclk    = r_sclk;
    w_cs_n    = r_cs_n;
    w_ldac_n  = r_ldac_n;
    w_done    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          // Word A goes straight into the shifter; only channel B's code
          // needs holding until its frame starts.
          w_code_b  = w_code_b_in;
          w_shreg   = w_word_a;
          w_cs_n    = 1'b0;
          w_sclk    = 1'b0;
          w_div_cnt = '0;
          w_bit_cnt = '0;
          w_state   = S_SHIFT_A;
        end
      end

      S_SHIFT_A, S_SHIFT_B: begin
        if (r_div_cnt == c_div_last) begin
          w_div_cnt = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
          end else if (r_bit_cnt == c_bit_last) begin
            // End of frame: clearing the shifter also forces MOSI low.
            w_sclk    = 1'b0;
            w_cs_n    = 1'b1;
            w_shreg   = '0;
            w_aux_cnt = '0;
            w_state   = (r_state == S_SHIFT_A) ? S_GAP_A : S_GAP_B;
          end else begin
            // Falling SCLK edge is the only place MOSI advances mid-frame.
            w_sclk    = 1'b0;
            w_bit_cnt = r_bit_cnt + 1'b1;
            w_shreg   = {r_shreg[FRAME_W-2:0], 1'b0};
          end
        end else begin
          w_div_cnt = r_div_cnt + 1'b1;
        end
      end

      S_GAP_A: begin
        if (r_aux_cnt == c_gap_last) begin
          w_shreg   = w_word_b;
          w_cs_n    = 1'b0;
          w_sclk    = 1'b0;
          w_div_cnt = '0;
          w_bit_cnt = '0;
          w_state   = S_SHIFT_B;
        end else begin
          w_aux_cnt = r_aux_cnt + 1'b1;
        end
      end

      S_GAP_B: begin
        if (r_aux_cnt == c_gap_last) begin
          w_ldac_n  = 1'b0;
          w_aux_cnt = '0;
          w_state   = S_LATCH;
        end else begin
          w_aux_cnt = r_aux_cnt + 1'b1;
        end
      end

      S_LATCH: begin
        if (r_aux_cnt == c_lat_last) begin
          w_ldac_n = 1'b1;
          w_done   = 1'b1;
          w_state  = S_IDLE;
        end else begin
          w_aux_cnt = r_aux_cnt + 1'b1;
        end
      end

      default: begin
        w_state  = S_IDLE;
        w_cs_n   = 1'b1;
        w_ldac_n = 1'b1;
        w_sclk   = 1'b0;
        w_shreg  = '0;
      end
    endcase
  end

  assign bus.DAC_SCLK   = r_sclk;
  assign bus.DAC_MOSI   = r_shreg[FRAME_W-1];
  assign bus.DAC_CS_N   = r_cs_n;
  assign bus.DAC_LDAC_N = r_ldac_n;
  assign bus.BUSY       = (r_state != S_IDLE);
  assign bus.FRAME_DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ddfs_dual_dac_spi_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddfs_dual_dac_spi_driver
// Purpose  : Directed self-checking bench for ddfs_dual_dac_spi_driver.
//            dut0 runs defaults; dut1 (CLK_DIV=1) and dut2 (CLK_DIV=5)
//            cover the divider range.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddfs_dual_dac_spi_driver;

  logic clock_100_MHz = 1'b0;
  logic clear_DAC;
  always #5 clock_100_MHz = ~clock_100_MHz;

  ddfs_dual_dac_spi_driver_if #(.DATA_W(16)) bus0 ();
  ddfs_dual_dac_spi_driver_if #(.DATA_W(16)) bus1 ();
  ddfs_dual_dac_spi_driver_if #(.DATA_W(16)) bus2 ();

  ddfs_dual_dac_spi_driver #(.CLK_DIV(2)) dut0 (
    .clock_100_MHz(clock_100_MHz), .clear_DAC(clear_DAC), .bus(bus0));
  ddfs_dual_dac_spi_driver #(.CLK_DIV(1)) dut1 (
    .clock_100_MHz(clock_100_MHz), .clear_DAC(clear_DAC), .bus(bus1));
  ddfs_dual_dac_spi_driver #(.CLK_DIV(5)) dut2 (
    .clock_100_MHz(clock_100_MHz), .clear_DAC(clear_DAC), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- dut0 frame monitor (samples mid-cycle) ----------------
  int          cyc = 0;
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_ldac = 1'b1, p_busy = 1'b0;
  logic [15:0] sh = '0;
  int          edges = 0, cslen = 0, hicnt = 0, ldlen = 0, fcnt = 0, gcnt = 0;
  logic [15:0] word_rec [2];
  int          cslen_rec [2];
  int          edges_rec [2];
  int          gap_rec [2];
  int          cap_time [4];
  int          ldac_rec = 0, fd_total = 0, ncap = 0, lowrun = 0, lowrun_rec = 0;

  always @(negedge clock_100_MHz) begin
    cyc++;
    if (clear_DAC) begin
      edges = 0; cslen = 0; hicnt = 0; ldlen = 0; fcnt = 0; gcnt = 0;
      p_sclk = 1'b0; p_cs = 1'b1; p_ldac = 1'b1; p_busy = 1'b0;
    end else begin
      if (bus0.BUSY && !p_busy) begin
        fcnt = 0; gcnt = 0;
        cap_time[ncap % 4] = cyc;
        ncap++;
        lowrun_rec = lowrun;
      end
      lowrun = bus0.BUSY ? 0 : lowrun + 1;
      if (!bus0.DAC_CS_N) begin
        if (p_cs) begin
          sh = '0; edges = 0; cslen = 0;
          if (hicnt > 0) begin gap_rec[gcnt % 2] = hicnt; gcnt++; hicnt = 0; end
        end
        cslen++;
        if (bus0.DAC_SCLK && !p_sclk) begin sh = {sh[14:0], bus0.DAC_MOSI}; edges++; end
      end else begin
        if (!p_cs) begin
          word_rec[fcnt % 2] = sh; cslen_rec[fcnt % 2] = cslen; edges_rec[fcnt % 2] = edges;
          fcnt++;
        end
        if (bus0.BUSY && bus0.DAC_LDAC_N) hicnt++;
      end
      if (!bus0.DAC_LDAC_N) begin
        if (p_ldac) begin gap_rec[gcnt % 2] = hicnt; gcnt++; hicnt = 0; ldlen = 0; end
        ldlen++;
      end else if (!p_ldac) begin
        ldac_rec = ldlen;
      end
      if (bus0.FRAME_DONE) fd_total++;
      p_sclk = bus0.DAC_SCLK; p_cs = bus0.DAC_CS_N; p_ldac = bus0.DAC_LDAC_N; p_busy = bus0.BUSY;
    end
  end

  // ---------------- sweep monitors: CS width, SCLK edges and period --------
  logic        p_cs1 = 1'b1, p_sclk1 = 1'b0, p_cs2 = 1'b1, p_sclk2 = 1'b0;
  int          c1 = 0, l1 = 0, e1 = 0, last1 = 0, per1 = 0, l1_rec = 0, e1_rec = 0;
  int          c2 = 0, l2 = 0, e2 = 0, last2 = 0, per2 = 0, l2_rec = 0, e2_rec = 0;
  logic [15:0] sh1 = '0, w1_rec = '0;

  always @(negedge clock_100_MHz) begin
    c1++;
    if (!bus1.DAC_CS_N) begin
      if (p_cs1) begin l1 = 0; e1 = 0; sh1 = '0; end
      l1++;
      if (bus1.DAC_SCLK && !p_sclk1) begin
        if (e1 > 0) per1 = c1 - last1;
        last1 = c1; e1++; sh1 = {sh1[14:0], bus1.DAC_MOSI};
      end
    end else if (!p_cs1) begin
      l1_rec = l1; e1_rec = e1; w1_rec = sh1;
    end
    p_cs1 = bus1.DAC_CS_N; p_sclk1 = bus1.DAC_SCLK;
  end

  always @(negedge clock_100_MHz) begin
    c2++;
    if (!bus2.DAC_CS_N) begin
      if (p_cs2) begin l2 = 0; e2 = 0; end
      l2++;
      if (bus2.DAC_SCLK && !p_sclk2) begin
        if (e2 > 0) per2 = c2 - last2;
        last2 = c2; e2++;
      end
    end else if (!p_cs2) begin
      l2_rec = l2; e2_rec = e2;
    end
    p_cs2 = bus2.DAC_CS_N; p_sclk2 = bus2.DAC_SCLK;
  end

  // One enable pulse on dut0; lat = cycle (1 = first cycle after the capture
  // edge) in which FRAME_DONE is high.
  task automatic txn0(input logic [15:0] c, input logic [15:0] s, input bit scramble, output int lat);
    @(negedge clock_100_MHz);
    bus0.COSINE_IN = c; bus0.SINE_IN = s; bus0.enable = 1'b1;
    @(posedge clock_100_MHz); #1;
    bus0.enable = 1'b0;
    lat = 1;
    while (bus0.FRAME_DONE !== 1'b1 && lat < 1000) begin
      if (scramble) begin
        bus0.COSINE_IN = 16'($urandom);
        bus0.SINE_IN   = 16'($urandom);
      end
      @(posedge clock_100_MHz); #1;
      lat++;
    end
    repeat (2) @(negedge clock_100_MHz);
  endtask

  int lat, base_fd, base_cap, t, caps, fds;
  logic prev_busy;

  initial begin
    clear_DAC = 1'b1;
    bus0.enable = 1'b0; bus0.COSINE_IN = '0; bus0.SINE_IN = '0;
    bus1.enable = 1'b0; bus1.COSINE_IN = '0; bus1.SINE_IN = '0;
    bus2.enable = 1'b0; bus2.COSINE_IN = '0; bus2.SINE_IN = '0;
    #2;
    check("rst_cs_n", bus0.DAC_CS_N, 1);
    check("rst_sclk", bus0.DAC_SCLK, 0);
    check("rst_mosi", bus0.DAC_MOSI, 0);
    check("rst_ldac_n", bus0.DAC_LDAC_N, 1);
    check("rst_busy", bus0.BUSY, 0);
    check("rst_frame_done", bus0.FRAME_DONE, 0);
    repeat (3) @(negedge clock_100_MHz);
    clear_DAC = 1'b0;
    repeat (2) @(negedge clock_100_MHz);

    // Single transaction at defaults
    base_fd = fd_total;
    txn0(16'h4E20, 16'h0000, 1'b0, lat);
    check("t1_latency", lat, 135);
    check("t1_frames", fcnt, 2);
    check("t1_word_a", word_rec[0], 16'h3CE2);
    check("t1_word_b", word_rec[1], 16'hB800);
    check("t1_cs_low_a", cslen_rec[0], 64);
    check("t1_cs_low_b", cslen_rec[1], 64);
    check("t1_sclk_edges_a", edges_rec[0], 16);
    check("t1_sclk_edges_b", edges_rec[1], 16);
    check("t1_gap_a", gap_rec[0], 2);
    check("t1_gap_b", gap_rec[1], 2);
    check("t1_ldac_low", ldac_rec, 2);
    check("t1_done_pulses", fd_total - base_fd, 1);
    check("t1_busy_after", bus0.BUSY, 0);

    // Conversion extremes
    txn0(16'h7FFF, 16'h8000, 1'b0, lat);
    check("ext_word_a", word_rec[0], 16'h3FFF);
    check("ext_word_b", word_rec[1], 16'hB000);
    txn0(16'hB1E0, 16'hB1E0, 1'b0, lat);
    check("b1e0_word_a", word_rec[0], 16'h331E);
    check("b1e0_word_b", word_rec[1], 16'hB31E);

    // Inputs scrambled every cycle after capture
    txn0(16'h1234, 16'hFEDC, 1'b1, lat);
    check("scr_latency", lat, 135);
    check("scr_word_a", word_rec[0], 16'h3923);
    check("scr_word_b", word_rec[1], 16'hB7ED);

    // Continuous mode: three back-to-back transactions
    base_fd = fd_total; base_cap = ncap;
    @(negedge clock_100_MHz);
    bus0.COSINE_IN = 16'h0000; bus0.SINE_IN = 16'h7FFF; bus0.enable = 1'b1;
    caps = 0; fds = 0; t = 0; prev_busy = 1'b0;
    while (fds < 3 && t < 2000) begin
      @(posedge clock_100_MHz); #1;
      t++;
      if (bus0.BUSY && !prev_busy) begin
        caps++;
        if (caps == 3) bus0.enable = 1'b0;
      end
      if (bus0.FRAME_DONE) fds++;
      prev_busy = bus0.BUSY;
    end
    bus0.enable = 1'b0;
    repeat (150) @(negedge clock_100_MHz);
    check("cont_captures", ncap - base_cap, 3);
    check("cont_done_pulses", fd_total - base_fd, 3);
    check("cont_period_1", cap_time[(base_cap + 1) % 4] - cap_time[base_cap % 4], 135);
    check("cont_period_2", cap_time[(base_cap + 2) % 4] - cap_time[(base_cap + 1) % 4], 135);
    check("cont_busy_low_gap", lowrun_rec, 1);
    check("cont_word_b", word_rec[1], 16'hBFFF);

    // Divider sweep
    @(negedge clock_100_MHz);
    bus1.COSINE_IN = 16'h7FFF; bus1.SINE_IN = 16'h8000; bus1.enable = 1'b1;
    bus2.COSINE_IN = 16'h7FFF; bus2.SINE_IN = 16'h8000; bus2.enable = 1'b1;
    @(posedge clock_100_MHz); #1;
    bus1.enable = 1'b0; bus2.enable = 1'b0;
    t = 0;
    while (bus2.FRAME_DONE !== 1'b1 && t < 1000) begin
      @(posedge clock_100_MHz); #1;
      t++;
    end
    repeat (3) @(negedge clock_100_MHz);
    check("div1_cs_low", l1_rec, 32);
    check("div1_sclk_edges", e1_rec, 16);
    check("div1_sclk_period", per1, 2);
    check("div1_word_b", w1_rec, 16'hB000);
    check("div5_cs_low", l2_rec, 160);
    check("div5_sclk_edges", e2_rec, 16);
    check("div5_sclk_period", per2, 10);

    // Reset in the middle of frame A
    base_fd = fd_total;
    @(negedge clock_100_MHz);
    bus0.COSINE_IN = 16'h4E20; bus0.SINE_IN = 16'h0000; bus0.enable = 1'b1;
    @(posedge clock_100_MHz); #1;
    bus0.enable = 1'b0;
    repeat (2) @(posedge clock_100_MHz);
    #1;
    t = 0;
    while (edges < 7 && t < 200) begin
      @(posedge clock_100_MHz); #1;
      t++;
    end
    check("mid_reset_reached_bit7", (t < 200) && (bus0.DAC_CS_N == 1'b0), 1);
    #2 clear_DAC = 1'b1;
    #1;
    check("mid_reset_cs_n", bus0.DAC_CS_N, 1);
    check("mid_reset_sclk", bus0.DAC_SCLK, 0);
    check("mid_reset_ldac_n", bus0.DAC_LDAC_N, 1);
    check("mid_reset_busy", bus0.BUSY, 0);
    repeat (2) @(negedge clock_100_MHz);
    clear_DAC = 1'b0;
    repeat (300) @(posedge clock_100_MHz);
    #1;
    check("post_reset_no_done", fd_total - base_fd, 0);
    check("post_reset_idle", bus0.BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddfs_dual_dac_spi_driver.md
Name: ddfs_dual_dac_spi_driver

Overview:
Downstream stage of the CORDIC DDFS core. It snapshots the 16-bit signed COSINE/SINE sample pair, converts each sample to 12-bit offset-binary, and shifts both out as two 16-bit SPI frames to a dual-channel 12-bit DAC. Frame format: A/B select, BUF, GA_n, SHDN_n, then 12 data bits. After both frames it pulses LDAC_N low so both DAC outputs update together.

Parameters:
DATA_W, 16, width of the incoming DDFS samples (must equal the DDFS SAN_CP).
DAC_BITS, 12, DAC resolution; code = sample[DATA_W-1 -: DAC_BITS] with MSB inverted.
CLK_DIV, 2, clock cycles per SCLK half-period (≥1).
CS_GAP, 2, clock cycles CS_N is held high between frames and after frame B (≥1).
LDAC_W, 2, clock cycles LDAC_N is held low (≥1).

Ports:
clock_100_MHz  input  1  system clock; all logic on the rising edge.
clear_DAC  input  1  asynchronous, active-high reset.
enable  input  1  level request; sampled only in IDLE.
COSINE_IN  input  DATA_W  signed cosine sample; goes to DAC channel A.
SINE_IN  input  DATA_W  signed sine sample; goes to DAC channel B.
DAC_SCLK  output  1  SPI clock, idle low; the DAC samples on its rising edge.
DAC_MOSI  output  1  serial data, MSB first.
DAC_CS_N  output  1  active-low chip select.
DAC_LDAC_N  output  1  active-low latch strobe.
BUSY  output  1  high whenever state ≠ IDLE.
FRAME_DONE  output  1  one-cycle pulse when a transaction completes.

Behaviour:
- Reset: async on clear_DAC=1.
  - Outputs: DAC_SCLK=0, DAC_MOSI=0, DAC_CS_N=1, DAC_LDAC_N=1, BUSY=0, FRAME_DONE=0.
  - State IDLE; snapshot registers cleared.
  - Reset asserted mid-transaction aborts it immediately; no LDAC pulse, no FRAME_DONE.
- States: IDLE → SHIFT_A → GAP_A → SHIFT_B → GAP_B → LATCH → IDLE.
- IDLE, on an edge with enable=1:
  - Register COSINE_IN and SINE_IN.
  - Build word A = {0,0,1,1,codeA} and word B = {1,0,1,1,codeB}.
  - Same edge: CS_N←0, MOSI←wordA[15], SCLK←0, state←SHIFT_A.
- SHIFT_x: each bit lasts 2·CLK_DIV cycles: CLK_DIV with SCLK low, then CLK_DIV with SCLK high.
  - MOSI changes only on the edge where SCLK goes low, or at frame start.
  - After the 16th bit's high phase, on the same edge: SCLK←0, CS_N←1, MOSI←0.
  - CS_N is low for exactly 32·CLK_DIV cycles per frame. Exactly 16 rising SCLK edges per frame.
- GAP_x: CS_N high for CS_GAP cycles.
  - GAP_A exits to SHIFT_B, which starts with the same entry rules using wordB.
  - GAP_B exits to LATCH.
- LATCH: LDAC_N low for LDAC_W cycles.
  - On the edge where LDAC_N returns high: FRAME_DONE=1 for one cycle, state←IDLE.
- Throughput: enable held high starts a new capture the cycle after FRAME_DONE. Capture-to-capture period = 64·CLK_DIV + 2·CS_GAP + LDAC_W + 1 (135 at defaults).
- Sample handling:
  - Inputs are sampled only at capture. Input changes during a transaction have no effect.
  - enable deasserting mid-transaction is ignored; the transaction completes.
- Conversion: truncate (no rounding), then invert MSB. Examples:
  - 0x0000→0x800
  - 0x7FFF→0xFFF
  - 0x8000→0x000
  - 0x4E20→0xCE2
  - 0xB1E0→0x31E
- Counters (bit count 0–15, divider, gap/latch counters) are sized from their parameters. No counter wraps beyond its terminal value.

Test Plan:
- Reset check: assert clear_DAC mid-SHIFT_A (bit 7) → next sim step CS_N=1, SCLK=0, LDAC_N=1, BUSY=0. After release, no FRAME_DONE until a new enable.
- Single transaction, defaults: COSINE_IN=0x4E20, SINE_IN=0x0000, enable pulsed one cycle.
  - Frame A bits = 0x3CE2; frame B bits = 0xB800.
  - CS_N low 64 cycles per frame, gap 2 cycles, LDAC_N low 2 cycles.
  - FRAME_DONE exactly 135 cycles after the capture edge.
- Conversion extremes: cos=0x7FFF, sin=0x8000 → words 0x3FFF and 0xB000. Cos=0xB1E0 → code 0x31E.
- Input stability: change COSINE_IN/SINE_IN every cycle during a transaction → transmitted words match the values present at the capture edge only.
- Continuous mode: enable held high for 3 transactions → captures every 135 cycles, 3 FRAME_DONE pulses, BUSY low for exactly one cycle between transactions.
- Parameter sweep: CLK_DIV=1 → SCLK period 2 cycles, CS_N low 32 cycles per frame, 16 rising SCLK edges per frame. CLK_DIV=5 → CS_N low 160 cycles per frame.
